// File: rtl/irdy_trdy_fifo.sv
// Circular-buffer FIFO with irdy/trdy handshakes on both sides; any depth >= 2.
// Latency: first-word fall-through, a write is visible on data_out the next cycle. Backpressure: f2p_trdy drops only when full.
module irdy_trdy_fifo #(
    parameter int  SIZE      = 8,
    parameter int  T_SIZE    = 3,
    parameter type T         = logic [T_SIZE-1:0],
    parameter int  LOG_SIZE  = $clog2(SIZE),
    parameter int  AF_THRESH = SIZE - 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                p2f_irdy,
    input  T                    data_in,
    output logic                f2p_trdy,
    output logic                f2c_irdy,
    output T                    data_out,
    input  logic                c2f_trdy,
    output logic [LOG_SIZE:0]   occupancy,
    output logic                almost_full
);

    localparam logic [LOG_SIZE-1:0] LAST_IDX = LOG_SIZE'(SIZE - 1);
    localparam logic [LOG_SIZE:0]   SIZE_W   = (LOG_SIZE + 1)'(SIZE);
    localparam logic [LOG_SIZE:0]   AF_W     = (LOG_SIZE + 1)'(AF_THRESH);

    T                    Q [0:SIZE-1];
    logic [LOG_SIZE-1:0] rd_ptr;
    logic [LOG_SIZE-1:0] wr_ptr;
    logic                wrap;
    logic                enq;
    logic                deq;
    logic                full;
    logic                empty;
    logic                wr_last;
    logic                rd_last;

    // Equal pointers are disambiguated by the wrap bit: set means the writer is a lap ahead.
    assign full    = (rd_ptr == wr_ptr) && wrap;
    assign empty   = (rd_ptr == wr_ptr) && !wrap;
    assign f2p_trdy = !full;
    assign f2c_irdy = !empty;
    assign enq     = p2f_irdy && f2p_trdy;
    assign deq     = f2c_irdy && c2f_trdy;
    assign wr_last = (wr_ptr == LAST_IDX);
    assign rd_last = (rd_ptr == LAST_IDX);

    assign data_out = Q[rd_ptr];

    assign occupancy = wrap ? (SIZE_W - {1'b0, rd_ptr} + {1'b0, wr_ptr})
                            : ({1'b0, wr_ptr} - {1'b0, rd_ptr});
    assign almost_full = (occupancy >= AF_W);

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            wrap   <= 1'b0;
            for (int i = 0; i < SIZE; i++) begin
                Q[i] <= '0;
            end
        end else begin
            if (enq) begin
                Q[wr_ptr] <= data_in;
                wr_ptr    <= wr_last ? '0 : wr_ptr + 1'b1;
            end
            if (deq) begin
                rd_ptr <= rd_last ? '0 : rd_ptr + 1'b1;
            end
            // Both pointers wrapping together leaves the lap difference unchanged.
            if ((enq && wr_last) != (deq && rd_last)) begin
                wrap <= ~wrap;
            end
        end
    end

endmodule
